// File: rtl/calc_arb_pkg.sv
// calc_arb_pkg: shared types and widths for the calculator arbiter.
// Holds the arbiter state encoding, operand/function widths and the
// default watchdog limit used when CALC_ARB_TIMEOUT_EN is defined.
package calc_arb_pkg;

  localparam int OPW             = 4;
  localparam int FW              = 3;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/calc_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans requesters starting one past last_grant_i (wrapping at NUM_REQ)
// and reports the first one with its request bit set.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_grant_i,
  output logic               valid_o,
  output logic [IDW-1:0]     winner_id_o
);

  // Walk the ring from last_grant+1; the last slot visited is last_grant itself,
  // so a repeat requester always ends up with the lowest priority.
  always_comb begin
    int idx;
    valid_o     = 1'b0;
    winner_id_o = '0;
    idx         = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant_i) + off) % NUM_REQ;
      if (!valid_o && req_i[idx]) begin
        valid_o     = 1'b1;
        winner_id_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin front end sharing one calculator among NUM_REQ
// requesters. Grants a requester, latches its operands, pulses calc_go,
// waits for calc_done and returns the result with a one-cycle ack.
// Optional feature macro: CALC_ARB_TIMEOUT_EN adds a WAIT-state watchdog
// that aborts after TIMEOUT cycles and flags res_err.
module calc_arbiter
  import calc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [OPW*NUM_REQ-1:0] req_x,
  input  logic [OPW*NUM_REQ-1:0] req_y,
  input  logic [FW*NUM_REQ-1:0]  req_f,
  output logic [NUM_REQ-1:0]     ack,
  output logic [OPW-1:0]         res_h,
  output logic [OPW-1:0]         res_l,
  output logic                   res_err,
  output logic                   busy,
  output logic                   calc_go,
  output logic [OPW-1:0]         calc_x,
  output logic [OPW-1:0]         calc_y,
  output logic [FW-1:0]          calc_f,
  input  logic                   calc_done,
  input  logic [OPW-1:0]         calc_out_h,
  input  logic [OPW-1:0]         calc_out_l
);

  localparam int IDW = $clog2(NUM_REQ);

  // Reject watchdog limits that do not fit the 8-bit counter.
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("calc_arbiter: TIMEOUT must be in 1..255");
  end

  state_e               state_q, state_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [OPW-1:0]       x_q, x_d;
  logic [OPW-1:0]       y_q, y_d;
  logic [FW-1:0]        f_q, f_d;
  logic [OPW-1:0]       resh_q, resh_d;
  logic [OPW-1:0]       resl_q, resl_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 go_q, go_d;
  logic                 busy_q, busy_d;
  logic                 pick_valid;
  logic [IDW-1:0]       pick_id;

`ifdef CALC_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req_i        (req),
    .last_grant_i (last_q),
    .valid_o      (pick_valid),
    .winner_id_o  (pick_id)
  );

  // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    x_d     = x_q;
    y_d     = y_q;
    f_d     = f_q;
    resh_d  = resh_q;
    resl_d  = resl_q;
    ack_d   = '0;
`ifdef CALC_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_id;
          last_d  = pick_id;
          x_d     = req_x[pick_id*OPW +: OPW];
          y_d     = req_y[pick_id*OPW +: OPW];
          f_d     = req_f[pick_id*FW +: FW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef CALC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
`ifdef CALC_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (calc_done) begin
          resh_d         = calc_out_h;
          resl_d         = calc_out_l;
          ack_d[grant_q] = 1'b1;
          state_d        = RESP;
`ifdef CALC_ARB_TIMEOUT_EN
          err_d          = 1'b0;
        end else if (cnt_q == TimeoutLast) begin
          resh_d         = '0;
          resl_d         = '0;
          err_d          = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = RESP;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    go_d   = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      x_q     <= '0;
      y_q     <= '0;
      f_q     <= '0;
      resh_q  <= '0;
      resl_q  <= '0;
      ack_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      x_q     <= x_d;
      y_q     <= y_d;
      f_q     <= f_d;
      resh_q  <= resh_d;
      resl_q  <= resl_d;
      ack_q   <= ack_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
    end
  end

`ifdef CALC_ARB_TIMEOUT_EN
  // Watchdog counter and abort flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  assign ack     = ack_q;
  assign res_h   = resh_q;
  assign res_l   = resl_q;
  assign busy    = busy_q;
  assign calc_go = go_q;
  assign calc_x  = x_q;
  assign calc_y  = y_q;
  assign calc_f  = f_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed bench for calc_arbiter with a behavioural
// calculator and a scoreboard of expected acks/results.
// Timeout cases run when CALC_ARB_TIMEOUT_EN is defined.
module tb_calc_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 10;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_x;
  logic [4*NUM_REQ-1:0] req_y;
  logic [3*NUM_REQ-1:0] req_f;
  logic [NUM_REQ-1:0]   ack;
  logic [3:0]           res_h;
  logic [3:0]           res_l;
  logic                 res_err;
  logic                 busy;
  logic                 calc_go;
  logic [3:0]           calc_x;
  logic [3:0]           calc_y;
  logic [2:0]           calc_f;
  logic                 calc_done;
  logic [3:0]           calc_out_h;
  logic [3:0]           calc_out_l;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       err;
  } expEntry_t;

  expEntry_t expQ[$];
  int        vectors    = 0;
  int        miscompares = 0;
  int        ackCount   = 0;
  int        calcK      = 1;
  int        pend       = 0;
  bit        autoDrop   = 1'b1;

  calc_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_f      (req_f),
    .ack        (ack),
    .res_h      (res_h),
    .res_l      (res_l),
    .res_err    (res_err),
    .busy       (busy),
    .calc_go    (calc_go),
    .calc_x     (calc_x),
    .calc_y     (calc_y),
    .calc_f     (calc_f),
    .calc_done  (calc_done),
    .calc_out_h (calc_out_h),
    .calc_out_l (calc_out_l)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] calcFn(input logic [3:0] x, input logic [3:0] y, input logic [2:0] f);
    logic [7:0] r;
    case (f)
      3'd0:    r = {4'b0, x} + {4'b0, y};
      3'd1:    r = {4'b0, x} - {4'b0, y};
      3'd2:    r = {4'b0, x} * {4'b0, y};
      3'd3:    r = {4'b0, x & y};
      3'd4:    r = {4'b0, x | y};
      3'd5:    r = {4'b0, x ^ y};
      3'd6:    r = {4'b0, ~x};
      default: r = {x, y};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveReq(input int id, input logic [3:0] x, input logic [3:0] y, input logic [2:0] f);
    req_x[id*4 +: 4] = x;
    req_y[id*4 +: 4] = y;
    req_f[id*3 +: 3] = f;
    req[id]          = 1'b1;
  endtask

  task automatic pushExpected(input int id, input logic [3:0] x, input logic [3:0] y, input logic [2:0] f,
                              input logic err);
    expEntry_t e;
    e.id  = id;
    e.err = err;
    e.res = err ? 8'h00 : calcFn(x, y, f);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int id, input logic [3:0] x, input logic [3:0] y, input logic [2:0] f);
    driveReq(id, x, y, f);
    pushExpected(id, x, y, f, 1'b0);
  endtask

  task automatic waitAcks(input int target, input int budget, input string tag);
    int n = 0;
    while (ackCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(ackCount >= target), 32'd1);
  endtask

  // Behavioural calculator: raises calc_done for one cycle calcK cycles after calc_go.
  initial begin
    logic [7:0] r;
    calc_done  = 1'b0;
    calc_out_h = '0;
    calc_out_l = '0;
    forever begin
      @(negedge clk);
      calc_done = 1'b0;
      if (!rst) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            r          = calcFn(calc_x, calc_y, calc_f);
            calc_out_h = r[7:4];
            calc_out_l = r[3:0];
            calc_done  = 1'b1;
          end
        end
        if (calc_go && calcK > 0) pend = calcK;
      end
    end
  end

  // Scoreboard monitor: every ack is matched against the oldest expected entry.
  initial begin
    expEntry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ack !== '0) begin
        ackCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("ack_onehot", 32'(ack), 32'd1 << e.id);
          checkOutput("res_h", 32'(res_h), 32'(e.res[7:4]));
          checkOutput("res_l", 32'(res_l), 32'(e.res[3:0]));
          checkOutput("res_err", 32'(res_err), 32'(e.err));
        end
        if (autoDrop) req = req & ~ack;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    int base;
    rst   = 1'b1;
    req   = '0;
    req_x = '0;
    req_y = '0;
    req_f = '0;
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_outputs", 32'({ack, res_h, res_l, res_err, busy, calc_go, calc_x, calc_y, calc_f}), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] contention: all four requesters");
    autoDrop = 1'b1;
    calcK    = 2;
    base     = ackCount;
    applyStimulus(0, 4'd1, 4'd2, 3'd0);
    applyStimulus(1, 4'd7, 4'd7, 3'd2);
    applyStimulus(2, 4'hc, 4'h5, 3'd1);
    applyStimulus(3, 4'ha, 4'h6, 3'd5);
    waitAcks(base + 4, 200, "contention_acks");
    repeat (3) @(negedge clk);
    checkOutput("contention_idle", 32'(busy), 32'd0);

    $display("[TB] single request timing");
    calcK = 2;
    applyStimulus(0, 4'd5, 4'd3, 3'd0);
    @(negedge clk);
    checkOutput("single_go_n1", 32'({calc_go, busy}), 32'b11);
    checkOutput("single_x", 32'({calc_x, calc_y, calc_f}), 32'({4'd5, 4'd3, 3'd0}));
    @(negedge clk);
    checkOutput("single_go_n2", 32'({calc_go, busy}), 32'b01);
    @(negedge clk);
    checkOutput("single_ack_n3", 32'(ack), 32'd0);
    @(negedge clk);
    checkOutput("single_ack_n4", 32'({ack, res_h, res_l}), 32'({4'b0001, 4'd0, 4'd8}));
    @(negedge clk);
    checkOutput("single_after", 32'({ack, busy}), 32'd0);

    $display("[TB] fairness: req 0 and 1 held");
    autoDrop = 1'b0;
    calcK    = 1;
    base     = ackCount;
    applyStimulus(1, 4'd9, 4'd2, 3'd1);
    applyStimulus(0, 4'd3, 4'd4, 3'd2);
    pushExpected(1, 4'd9, 4'd2, 3'd1, 1'b0);
    pushExpected(0, 4'd3, 4'd4, 3'd2, 1'b0);
    waitAcks(base + 4, 200, "fairness_acks");
    req = '0;
    repeat (3) @(negedge clk);
    checkOutput("fairness_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("fairness_idle", 32'(busy), 32'd0);

    $display("[TB] operand change after grant");
    autoDrop = 1'b1;
    calcK    = 3;
    applyStimulus(1, 4'd9, 4'd6, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) driveReq(1, 4'hf, 4'hf, 3'd7);
      checkOutput("midop_operands", 32'({busy, calc_x, calc_y, calc_f}), 32'({1'b1, 4'd9, 4'd6, 3'd2}));
    end
    repeat (2) @(negedge clk);
    checkOutput("midop_idle", 32'(busy), 32'd0);

    $display("[TB] reset during WAIT");
    calcK = 0;
    driveReq(2, 4'd1, 4'd1, 3'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_in_wait_busy", 32'({busy, calc_go}), 32'b10);
    #2 rst = 1'b0;
    req = '0;
    #1;
    checkOutput("rst_mid_outputs", 32'({ack, res_h, res_l, res_err, busy, calc_go, calc_x, calc_y, calc_f}), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    calcK = 1;
    base  = ackCount;
    applyStimulus(0, 4'd2, 4'd2, 3'd4);
    applyStimulus(3, 4'd8, 4'd1, 3'd0);
    waitAcks(base + 2, 200, "post_reset_acks");
    repeat (3) @(negedge clk);

`ifdef CALC_ARB_TIMEOUT_EN
    $display("[TB] watchdog abort");
    calcK = 0;
    driveReq(2, 4'd3, 4'd4, 3'd0);
    pushExpected(2, 4'd3, 4'd4, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("tmo_issue", 32'(calc_go), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("tmo_wait_noack", 32'(ack), 32'd0);
    end
    @(negedge clk);
    checkOutput("tmo_ack", 32'({ack, res_err, res_h, res_l}), 32'({4'b0100, 1'b1, 8'h00}));
    repeat (3) @(negedge clk);

    $display("[TB] done on timeout cycle");
    calcK = 10;
    applyStimulus(1, 4'd6, 4'd9, 3'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("tmo2_wait_noack", 32'(ack), 32'd0);
    end
    @(negedge clk);
    checkOutput("tmo2_ack", 32'({ack, res_err, res_h, res_l}), 32'({4'b0010, 1'b0, 8'h0f}));
    repeat (3) @(negedge clk);
`endif

    checkOutput("final_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("final_idle", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Round-robin front end that shares one calculator (4-bit x/y, 3-bit function code, Go/Done handshake, 8-bit result split Out_H/Out_L) among NUM_REQ requesters. It arbitrates pending requests, latches the winner's operands, drives the calculator's Go, waits for Done, captures the result and returns it to the winner with a one-cycle ack. It sits between the requesting logic and the calculator top level, and it is the only block that drives the calculator's Go input.

## Interface
- NUM_REQ, default 4, number of requesters (2..8)
- TIMEOUT, default 255, watchdog limit in cycles (used only with CALC_ARB_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- req  in  NUM_REQ  per-requester request level
- req_x  in  4*NUM_REQ  operand x, slice i belongs to requester i
- req_y  in  4*NUM_REQ  operand y, slice i
- req_f  in  3*NUM_REQ  function code, slice i
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- res_h, res_l  out  4 each  result; valid only while ack is nonzero
- res_err  out  1  timeout abort flag; valid only with ack
- busy  out  1  high in every state except IDLE
- calc_go  out  1  Go to the calculator
- calc_x, calc_y  out  4 each  latched operands
- calc_f  out  3  latched function code
- calc_done  in  1  calculator Done
- calc_out_h, calc_out_l  in  4 each  calculator result

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If req is nonzero: pick a winner round-robin and register grant_id.
  - Latch the winner's x, y and f into calc_x, calc_y and calc_f. Go to ISSUE.
- Round-robin rule
  - Search starts at last_grant+1 modulo NUM_REQ. The first requester with req high wins.
  - last_grant updates when a requester is granted.
- ISSUE
  - calc_go=1 for exactly one cycle. Go to WAIT.
- WAIT
  - calc_go=0.
  - On the first cycle with calc_done=1: capture calc_out_h and calc_out_l into res_h and res_l, set res_err=0, go to RESP.
- RESP
  - ack[grant_id]=1 for one cycle, with res_h, res_l and res_err valid. Go to IDLE.
- Operand stability
  - calc_x, calc_y and calc_f hold from ISSUE through RESP.
  - Requester inputs are sampled only in IDLE. A change after the grant has no effect.
- Requester protocol
  - A requester holds req until it sees its ack, then drops req the next cycle.
  - If req is still high in the IDLE cycle after RESP, it counts as a new request. It has the lowest priority because its id equals last_grant.
- Simultaneous events
  - A req that rises during ISSUE, WAIT or RESP waits for IDLE.
  - calc_done=1 during IDLE or ISSUE is ignored.
- Reset
  - Asynchronous, any state. Next state is IDLE.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All outputs go to 0: ack, res_h, res_l, res_err, busy, calc_go, calc_x, calc_y, calc_f.
  - Any in-flight operation is abandoned with no ack. The calculator shares rst.

## Timing
- All outputs are registered.
- Cycle n: req sampled in IDLE. n+1: ISSUE, calc_go=1. Done first seen at n+1+k (k≥1). Ack at n+2+k.
- Minimum request-to-ack latency is k+2 cycles.
- A new grant can occur no earlier than the cycle after RESP. Back-to-back throughput is one operation per k+3 cycles.
- busy=1 from ISSUE through RESP inclusive.

## Configuration
- Macro: CALC_ARB_TIMEOUT_EN.
- Defined
  - An 8-bit watchdog counter clears in ISSUE and increments each WAIT cycle.
  - When it reaches TIMEOUT with calc_done still 0: go to RESP with res_h=0, res_l=0, res_err=1.
  - calc_done and the timeout in the same cycle: calc_done wins and res_err=0.
- Not defined
  - No counter is built. WAIT lasts indefinitely and res_err is tied to 0.

## Structure
- Package calc_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - OPW=4 (operand width) and FW=3 (function width)
  - default TIMEOUT value
- Sub-module rr_pick: combinational. Inputs are req and last_grant; outputs are a valid flag and winner_id.

## Test plan
- Single request: req=0001 with x=5, y=3, f=add, calculator k=2.
  - calc_go pulses at n+1. Ack=0001 at n+4 with res_h=0, res_l=8.
- Contention: req=1111 held, each requester dropping req after its ack.
  - Grants occur in order 0,1,2,3. Exactly one ack per operation.
- Fairness: req=0011 held continuously.
  - Grants alternate 0,1,0,1.
- Mid-operation change: change requester 1's inputs after its grant.
  - calc_x, calc_y and calc_f stay at the granted values through RESP.
- Reset in WAIT: assert rst low.
  - All outputs read 0 immediately, no ack is issued, next grant goes to requester 0.
- With CALC_ARB_TIMEOUT_EN and TIMEOUT=10: calc_done held at 0.
  - Ack comes 11 cycles after ISSUE with res_err=1 and res_h=res_l=0.
  - Repeat with calc_done arriving on the timeout cycle: res_err=0.
